// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared controller state encoding and line-word select constants
package dcache_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MISS,
      S_WRITEBACK,
      S_REFILL,
      S_REFILLOK
   } dc_state_t;

   // A line is an array of 32-bit words; address bits [1:0] select bytes and are ignored.
   localparam int WORD_W   = 32;
   localparam int WORD_LSB = 2;

endpackage

// File: rtl/dcache_way_array.sv
// rtl/dcache_way_array.sv - one cache way: per-set valid, dirty, tag and line storage
module dcache_way_array #(
   parameter int INDEX_W = 5,
   parameter int TAG_W   = 22,
   parameter int LINE_W  = 256
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               valid,
   output logic               dirty,
   output logic [TAG_W-1:0]   tag,
   output logic [LINE_W-1:0]  line,
   input  logic               upd,
   input  logic [INDEX_W-1:0] upd_index,
   input  logic [TAG_W-1:0]   upd_tag,
   input  logic [LINE_W-1:0]  upd_line,
   input  logic               upd_dirty
);

   localparam int SETS = 2**INDEX_W;

   logic [SETS-1:0]   valid_q;
   logic [SETS-1:0]   dirty_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [LINE_W-1:0] data_q [SETS];

   // Only the status bits reset; tag and data are qualified by valid.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (upd) begin
         valid_q[upd_index] <= 1'b1;
         dirty_q[upd_index] <= upd_dirty;
      end
   end

   always_ff @(posedge clk_i) begin
      if (upd) begin
         tag_q[upd_index]  <= upd_tag;
         data_q[upd_index] <= upd_line;
      end
   end

   assign valid = valid_q[rd_index];
   assign dirty = dirty_q[rd_index];
   assign tag   = tag_q[rd_index];
   assign line  = data_q[rd_index];

endmodule

// File: rtl/dcache_2way_ctrl.sv
// rtl/dcache_2way_ctrl.sv - 2-way set-associative write-back, write-allocate data cache controller
// Define DCACHE_STATS_EN to add saturating hit_cnt_o / miss_cnt_o counters.
module dcache_2way_ctrl
   import dcache_pkg::*;
#(
   parameter int  INDEX_W  = 5,
   parameter int  OFFSET_W = 5,
   localparam int LINE_W   = 8 * (2**OFFSET_W),
   localparam int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       p1_addr_i,
   input  logic [31:0]       p1_data_i,
   input  logic              p1_MemRead_i,
   input  logic              p1_MemWrite_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [LINE_W-1:0] mem_data_o,
   output logic [31:0]       mem_addr_o,
   output logic              mem_enable_o,
   output logic              mem_write_o
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   dc_state_t state;

   logic [TAG_W-1:0]    p1_tag;
   logic [INDEX_W-1:0]  p1_index;
   logic [OFFSET_W-3:0] p1_word;
   logic                unused_byte_bits;

   assign p1_tag           = p1_addr_i[31 -: TAG_W];
   assign p1_index         = p1_addr_i[OFFSET_W +: INDEX_W];
   assign p1_word          = p1_addr_i[OFFSET_W-1:WORD_LSB];
   assign unused_byte_bits = ^p1_addr_i[WORD_LSB-1:0];

   logic [1:0]        way_valid, way_dirty, way_hit, way_upd;
   logic [TAG_W-1:0]  way_tag  [2];
   logic [LINE_W-1:0] way_line [2];

   logic [INDEX_W-1:0] upd_index;
   logic [TAG_W-1:0]   upd_tag;
   logic [LINE_W-1:0]  upd_line;
   logic               upd_dirty;

   for (genvar w = 0; w < 2; w++) begin : g_way
      dcache_way_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .rd_index  (p1_index),
         .valid     (way_valid[w]),
         .dirty     (way_dirty[w]),
         .tag       (way_tag[w]),
         .line      (way_line[w]),
         .upd       (way_upd[w]),
         .upd_index (upd_index),
         .upd_tag   (upd_tag),
         .upd_line  (upd_line),
         .upd_dirty (upd_dirty)
      );
      assign way_hit[w] = way_valid[w] && (way_tag[w] == p1_tag);
   end

   logic              req, hit, hit_way, serve;
   logic [LINE_W-1:0] hit_line, merged_line;

   assign req        = p1_MemRead_i | p1_MemWrite_i;
   assign hit        = |way_hit;
   assign hit_way    = way_hit[1];
   assign hit_line   = way_line[hit_way];
   assign p1_stall_o = req & ~hit;
   assign p1_data_o  = (p1_MemRead_i && hit) ? hit_line[WORD_W*int'(p1_word) +: WORD_W] : '0;

   // REFILLOK is where the retried access of a miss completes, so hits are serviced there too.
   assign serve = req && hit && (state == S_IDLE || state == S_REFILLOK);

   always_comb begin
      merged_line = hit_line;
      merged_line[WORD_W*int'(p1_word) +: WORD_W] = p1_data_i;
   end

   logic               victim, victim_wb, new_victim;
   logic [TAG_W-1:0]   victim_tag, miss_tag;
   logic [INDEX_W-1:0] miss_index;
   logic [2**INDEX_W-1:0] lru;

   assign new_victim = !way_valid[0] ? 1'b0 :
                       !way_valid[1] ? 1'b1 : lru[p1_index];

   // Refill and write-hit never coincide: write hits are only taken outside REFILL.
   always_comb begin
      way_upd   = '0;
      upd_index = p1_index;
      upd_tag   = p1_tag;
      upd_line  = merged_line;
      upd_dirty = 1'b1;
      if (state == S_REFILL && mem_ack_i) begin
         way_upd[victim] = 1'b1;
         upd_index       = miss_index;
         upd_tag         = miss_tag;
         upd_line        = mem_data_i;
         upd_dirty       = 1'b0;
      end else if (serve && p1_MemWrite_i) begin
         way_upd[hit_way] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         lru <= '0;
      end else if (serve) begin
         lru[p1_index] <= ~hit_way;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= S_IDLE;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         victim       <= 1'b0;
         victim_wb    <= 1'b0;
         victim_tag   <= '0;
         miss_tag     <= '0;
         miss_index   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // Victim and miss address are captured here so the CPU may drop or change its request.
               if (req && !hit) begin
                  state      <= S_MISS;
                  victim     <= new_victim;
                  victim_wb  <= way_valid[new_victim] & way_dirty[new_victim];
                  victim_tag <= way_tag[new_victim];
                  mem_data_o <= way_line[new_victim];
                  miss_tag   <= p1_tag;
                  miss_index <= p1_index;
               end
            end
            S_MISS: begin
               mem_enable_o <= 1'b1;
               if (victim_wb) begin
                  state       <= S_WRITEBACK;
                  mem_write_o <= 1'b1;
                  mem_addr_o  <= {victim_tag, miss_index, {OFFSET_W{1'b0}}};
               end else begin
                  state       <= S_REFILL;
                  mem_write_o <= 1'b0;
                  mem_addr_o  <= {miss_tag, miss_index, {OFFSET_W{1'b0}}};
               end
            end
            S_WRITEBACK: begin
               if (mem_ack_i) begin
                  state       <= S_REFILL;
                  mem_write_o <= 1'b0;
                  mem_addr_o  <= {miss_tag, miss_index, {OFFSET_W{1'b0}}};
               end
            end
            S_REFILL: begin
               if (mem_ack_i) begin
                  state        <= S_REFILLOK;
                  mem_enable_o <= 1'b0;
               end
            end
            S_REFILLOK: state <= S_IDLE;
            default:    state <= S_IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (serve && hit_cnt_o != '1)
            hit_cnt_o <= hit_cnt_o + 32'd1;
         if (state == S_IDLE && req && !hit && miss_cnt_o != '1)
            miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// tb/tb_dcache_2way_ctrl.sv - self-checking bench for dcache_2way_ctrl with a reactive line memory
module tb_dcache_2way_ctrl;

   localparam int LINE_W = 256;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [31:0]       p1_addr_i, p1_data_i, p1_data_o, mem_addr_o;
   logic              p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
   logic [LINE_W-1:0] mem_data_i, mem_data_o;
   logic              mem_ack_i, mem_enable_o, mem_write_o;
`ifdef DCACHE_STATS_EN
   logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   dcache_2way_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .p1_addr_i     (p1_addr_i),
      .p1_data_i     (p1_data_i),
      .p1_MemRead_i  (p1_MemRead_i),
      .p1_MemWrite_i (p1_MemWrite_i),
      .p1_data_o     (p1_data_o),
      .p1_stall_o    (p1_stall_o),
      .mem_data_i    (mem_data_i),
      .mem_ack_i     (mem_ack_i),
      .mem_data_o    (mem_data_o),
      .mem_addr_o    (mem_addr_o),
      .mem_enable_o  (mem_enable_o),
      .mem_write_o   (mem_write_o)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt_o     (hit_cnt_o),
      .miss_cnt_o    (miss_cnt_o)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Memory: unwritten lines read back as 0xC000_0000 | word address.
   logic [LINE_W-1:0] store [logic [31:0]];
   int          mem_lat  = 2;
   bit          mem_hold = 1'b0;
   int          wait_cnt = 0;
   int          rd_cnt   = 0;
   int          wb_cnt   = 0;
   logic [31:0] rd_addr, wb_addr;
   logic [LINE_W-1:0] wb_line;

   function automatic logic [LINE_W-1:0] read_line(input logic [31:0] a);
      logic [LINE_W-1:0] l;
      if (store.exists(a)) return store[a];
      for (int j = 0; j < 8; j++) l[32*j +: 32] = 32'hC000_0000 | a | (j * 4);
      return l;
   endfunction

   initial begin
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk_i);
         if (mem_ack_i) begin
            mem_ack_i = 1'b0;
         end else if (mem_enable_o && !mem_hold) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
               wait_cnt  = 0;
               mem_ack_i = 1'b1;
               if (mem_write_o) begin
                  store[mem_addr_o] = mem_data_o;
                  wb_cnt++;
                  wb_addr = mem_addr_o;
                  wb_line = mem_data_o;
               end else begin
                  mem_data_i = read_line(mem_addr_o);
                  rd_cnt++;
                  rd_addr = mem_addr_o;
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Present one CPU access, wait out any stall, and complete it on the next rising edge.
   task automatic access(input logic [31:0] a, input bit we, input logic [31:0] wd,
                         output logic [31:0] rd, output int cyc);
      @(negedge clk_i);
      p1_addr_i     = a;
      p1_data_i     = wd;
      p1_MemWrite_i = we;
      p1_MemRead_i  = !we;
      #1;
      cyc = 0;
      while (p1_stall_o && cyc < 200) begin
         @(negedge clk_i);
         #1;
         cyc++;
      end
      rd = p1_data_o;
      @(posedge clk_i);
      #1;
      p1_MemRead_i  = 1'b0;
      p1_MemWrite_i = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
      bit          miss;
      logic [31:0] rdata;
      bit          wb;
      logic [31:0] wb_addr;
      logic [31:0] wb_word0;
      logic [31:0] fill_addr;
   } vec_t;

   vec_t vecs [13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          cyc, rd0, wb0;

      vecs[0]  = '{32'h0000_0404, 1'b0, 32'h0,         1'b1, 32'hC000_0404, 1'b0, 32'h0,         32'h0,         32'h0000_0400};
      vecs[1]  = '{32'h0000_0400, 1'b1, 32'hDEADBEEF,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0};
      vecs[2]  = '{32'h0000_0400, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF,  1'b0, 32'h0,         32'h0,         32'h0};
      vecs[3]  = '{32'h0000_0408, 1'b0, 32'h0,         1'b0, 32'hC000_0408, 1'b0, 32'h0,         32'h0,         32'h0};
      vecs[4]  = '{32'h0000_0000, 1'b0, 32'h0,         1'b1, 32'hC000_0000, 1'b0, 32'h0,         32'h0,         32'h0000_0000};
      vecs[5]  = '{32'h0000_0400, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF,  1'b0, 32'h0,         32'h0,         32'h0};
      vecs[6]  = '{32'h0000_0000, 1'b0, 32'h0,         1'b0, 32'hC000_0000, 1'b0, 32'h0,         32'h0,         32'h0};
      vecs[7]  = '{32'h0000_0800, 1'b0, 32'h0,         1'b1, 32'hC000_0800, 1'b1, 32'h0000_0400, 32'hDEADBEEF,  32'h0000_0800};
      vecs[8]  = '{32'h0000_0000, 1'b0, 32'h0,         1'b0, 32'hC000_0000, 1'b0, 32'h0,         32'h0,         32'h0};
      vecs[9]  = '{32'h0000_0400, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF,  1'b0, 32'h0,         32'h0,         32'h0000_0400};
      vecs[10] = '{32'h0000_0400, 1'b1, 32'h0000_0011, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0};
      vecs[11] = '{32'h0000_0000, 1'b0, 32'h0,         1'b0, 32'hC000_0000, 1'b0, 32'h0,         32'h0,         32'h0};
      vecs[12] = '{32'h0000_0C00, 1'b0, 32'h0,         1'b1, 32'hC000_0C00, 1'b1, 32'h0000_0400, 32'h0000_0011, 32'h0000_0C00};

      rst_i         = 1'b0;
      p1_addr_i     = '0;
      p1_data_i     = '0;
      p1_MemRead_i  = 1'b0;
      p1_MemWrite_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("reset mem_enable_o", {31'b0, mem_enable_o}, 32'd0);
      check("reset mem_write_o",  {31'b0, mem_write_o},  32'd0);
      check("reset p1_stall_o",   {31'b0, p1_stall_o},   32'd0);
      check("reset p1_data_o",    p1_data_o,             32'd0);
      rst_i = 1'b1;

      foreach (vecs[i]) begin
         rd0 = rd_cnt;
         wb0 = wb_cnt;
         access(vecs[i].addr, vecs[i].we, vecs[i].wdata, rd, cyc);
         check($sformatf("vec%0d completes", i), {31'b0, cyc < 200},        32'd1);
         check($sformatf("vec%0d miss", i),      {31'b0, cyc > 0},          {31'b0, vecs[i].miss});
         check($sformatf("vec%0d p1_data_o", i), rd,                        vecs[i].rdata);
         check($sformatf("vec%0d refills", i),   rd_cnt - rd0,              {31'b0, vecs[i].miss});
         check($sformatf("vec%0d writebacks", i), wb_cnt - wb0,             {31'b0, vecs[i].wb});
         if (vecs[i].miss)
            check($sformatf("vec%0d refill addr", i), rd_addr, vecs[i].fill_addr);
         if (vecs[i].wb) begin
            check($sformatf("vec%0d wb addr", i),  wb_addr,       vecs[i].wb_addr);
            check($sformatf("vec%0d wb word0", i), wb_line[31:0], vecs[i].wb_word0);
         end
      end

      // Clean miss with first-cycle ack: IDLE, MISS, REFILL, then REFILLOK releases the stall.
      mem_lat = 1;
      access(32'h0000_0020, 1'b0, 32'h0, rd, cyc);
      check("min miss latency", cyc, 32'd3);
      check("min miss data",    rd,  32'hC000_0020);
      mem_lat = 2;

      // CPU abandons its request while the miss is in flight.
      rd0 = rd_cnt;
      @(negedge clk_i);
      p1_addr_i    = 32'h0000_0060;
      p1_MemRead_i = 1'b1;
      @(posedge clk_i);
      #1;
      p1_MemRead_i = 1'b0;
      cyc = 0;
      while (rd_cnt == rd0 && cyc < 50) begin
         @(negedge clk_i);
         cyc++;
      end
      repeat (3) @(negedge clk_i);
      #1;
      check("dropped req refilled",  rd_cnt - rd0,            32'd1);
      check("dropped req stall",     {31'b0, p1_stall_o},     32'd0);
      check("dropped req data",      p1_data_o,               32'd0);
      check("dropped req mem idle",  {31'b0, mem_enable_o},   32'd0);
      access(32'h0000_0060, 1'b0, 32'h0, rd, cyc);
      check("dropped req later hit", cyc, 32'd0);
      check("dropped req later data", rd, 32'hC000_0060);

      // Reset while the refill is outstanding.
      mem_hold = 1'b1;
      @(negedge clk_i);
      p1_addr_i    = 32'h0000_0040;
      p1_MemRead_i = 1'b1;
      cyc = 0;
      while (!mem_enable_o && cyc < 20) begin
         @(negedge clk_i);
         cyc++;
      end
      check("refill enable",  {31'b0, mem_enable_o}, 32'd1);
      check("refill write",   {31'b0, mem_write_o},  32'd0);
      check("refill addr",    mem_addr_o,            32'h0000_0040);
      @(negedge clk_i);
      check("refill held enable", {31'b0, mem_enable_o}, 32'd1);
      check("refill held addr",   mem_addr_o,            32'h0000_0040);
      #2;
      rst_i = 1'b0;
      #1;
      check("async reset enable", {31'b0, mem_enable_o}, 32'd0);
      check("async reset write",  {31'b0, mem_write_o},  32'd0);
      p1_MemRead_i = 1'b0;
      mem_hold     = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      access(32'h0000_0040, 1'b0, 32'h0, rd, cyc);
      check("post-reset miss", {31'b0, cyc > 0}, 32'd1);
      check("post-reset data", rd, 32'hC000_0040);
      access(32'h0000_0404, 1'b0, 32'h0, rd, cyc);
      check("post-reset old line miss", {31'b0, cyc > 0}, 32'd1);

`ifdef DCACHE_STATS_EN
      begin
         logic [31:0] h0, m0;
         h0 = hit_cnt_o;
         m0 = miss_cnt_o;
         access(32'h0000_0080, 1'b0, 32'h0, rd, cyc);
         for (int k = 0; k < 3; k++) access(32'h0000_0084, 1'b0, 32'h0, rd, cyc);
         check("stats miss delta", miss_cnt_o - m0, 32'd1);
         check("stats hit delta",  hit_cnt_o - h0,  32'd4);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
